// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR unit.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  // Write/set/clear mode encodings
  localparam logic [2:0] WSC_NONE = 3'd0;
  localparam logic [2:0] WSC_W    = 3'd1;
  localparam logic [2:0] WSC_S    = 3'd2;
  localparam logic [2:0] WSC_C    = 3'd3;

  // Bit positions inside mstatus / mie / mip
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MEIE     = 11;
  localparam int unsigned MIP_MEIP     = 11;

  // Counter half width
  localparam int unsigned CNT_HALF_W = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLEEP = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
module csr_counter64
  import csr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  wr_lo,
  input  logic                  wr_hi,
  input  logic [CNT_HALF_W-1:0] wdata,
  output logic [63:0]           q
);

  logic [63:0] q_inc;

  // Increment with carry across halves; wraps naturally at 2^64
  always_comb begin
    q_inc = q + 64'(inc);
  end

  // A write to one half overrides only that half's increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q[31:0]  <= wr_lo ? wdata : q_inc[31:0];
      q[63:32] <= wr_hi ? wdata : q_inc[63:32];
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR register file and trap/WFI sequencer for the execute stage.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en_sig,
  input  logic            csr_read,
  input  logic            csr_write,
  input  logic            csr_MRET,
  input  logic            csr_WFI,
  input  logic            csr_imm_mode,
  input  logic [2:0]      csr_WSC_mode,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      zimm,
  input  logic [XLEN-1:0] pc,
  input  logic            ext_irq,
  input  logic            retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            stall_wfi
);

  state_t state, state_d;

  logic            mstatus_mie, mstatus_mpie, mie_meie, meip_q;
  logic [XLEN-1:0] mtvec_q, mepc_q, wake_pc_q;
  logic [63:0]     mcycle_q, minstret_q;

  logic [XLEN-1:0] src, old_val, new_val, trap_epc;
  logic            irq_pending, irq_take, wr_en, wr_mode_ok;
  logic            trap_entry, mret_fire, sleep_entry, csr_live;

  // Interrupt qualification
  always_comb begin
    irq_pending = meip_q & mie_meie;
    irq_take    = (state == ST_RUN) & mstatus_mie & irq_pending;
  end

  // Old-value read mux; unimplemented addresses read 0
  always_comb begin
    old_val = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        old_val[12:11]        = 2'b11;
        old_val[MSTATUS_MPIE] = mstatus_mpie;
        old_val[MSTATUS_MIE]  = mstatus_mie;
      end
      ADDR_MIE:       old_val[MIE_MEIE] = mie_meie;
      ADDR_MTVEC:     old_val = mtvec_q;
      ADDR_MEPC:      old_val = mepc_q;
      ADDR_MIP:       old_val[MIP_MEIP] = meip_q;
      ADDR_MCYCLE:    old_val = XLEN'(mcycle_q[31:0]);
      ADDR_MCYCLEH:   old_val = XLEN'(mcycle_q[63:32]);
      ADDR_MINSTRET:  old_val = XLEN'(minstret_q[31:0]);
      ADDR_MINSTRETH: old_val = XLEN'(minstret_q[63:32]);
      default:        old_val = '0;
    endcase
    csr_rdata = csr_read ? old_val : '0;
  end

  // Write/set/clear data and write qualification
  always_comb begin
    src        = csr_imm_mode ? XLEN'(zimm) : rs1_data;
    new_val    = old_val;
    wr_mode_ok = 1'b0;
    case (csr_WSC_mode)
      WSC_W: begin new_val = src;            wr_mode_ok = 1'b1;         end
      WSC_S: begin new_val = old_val | src;  wr_mode_ok = (src != '0);  end
      WSC_C: begin new_val = old_val & ~src; wr_mode_ok = (src != '0);  end
      default: begin new_val = old_val;      wr_mode_ok = 1'b0;         end
    endcase
    wr_en = csr_en_sig & csr_write & wr_mode_ok & csr_live;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_RUN: begin
        if (irq_take)                                    state_d = ST_TRAP;
        else if (csr_en_sig & csr_MRET)                  state_d = ST_RUN;
        else if (csr_en_sig & csr_WFI & ~irq_pending)    state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (irq_pending) state_d = mstatus_mie ? ST_TRAP : ST_RUN;
      end
      ST_TRAP: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs and sequencing strobes
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    stall_wfi   = 1'b0;
    trap_entry  = 1'b0;
    trap_epc    = '0;
    mret_fire   = 1'b0;
    sleep_entry = 1'b0;
    csr_live    = 1'b0;
    case (state)
      ST_RUN: begin
        csr_live = ~irq_take;
        if (irq_take) begin
          trap_entry = 1'b1;
          trap_epc   = pc;
        end else if (csr_en_sig & csr_MRET) begin
          redirect    = 1'b1;
          redirect_pc = mepc_q;
          mret_fire   = 1'b1;
        end else if (csr_en_sig & csr_WFI & ~irq_pending) begin
          sleep_entry = 1'b1;
        end
      end
      ST_SLEEP: begin
        stall_wfi = 1'b1;
        if (irq_pending & mstatus_mie) begin
          trap_entry = 1'b1;
          trap_epc   = wake_pc_q;
        end else if (irq_pending) begin
          redirect    = 1'b1;
          redirect_pc = wake_pc_q;
        end
      end
      ST_TRAP: begin
        redirect    = 1'b1;
        redirect_pc = mtvec_q;
      end
      default: begin
        redirect = 1'b0;
      end
    endcase
  end

  // CSR state: software writes, then trap entry / MRET updates take precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      meip_q       <= 1'b0;
      mtvec_q      <= {MTVEC_RST[XLEN-1:2], 2'b00};
      mepc_q       <= '0;
      wake_pc_q    <= '0;
    end else begin
      meip_q <= ext_irq;
      if (sleep_entry) wake_pc_q <= pc + XLEN'(4);
      if (wr_en) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= new_val[MSTATUS_MIE];
            mstatus_mpie <= new_val[MSTATUS_MPIE];
          end
          ADDR_MIE:   mie_meie <= new_val[MIE_MEIE];
          ADDR_MTVEC: mtvec_q  <= {new_val[XLEN-1:2], 2'b00};
          ADDR_MEPC:  mepc_q   <= {new_val[XLEN-1:2], 2'b00};
          default: ;
        endcase
      end
      if (trap_entry) begin
        mepc_q       <= {trap_epc[XLEN-1:2], 2'b00};
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_fire) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

  // Cycle and retired-instruction counters
  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wr_en & (csr_addr == ADDR_MCYCLE)),
    .wr_hi (wr_en & (csr_addr == ADDR_MCYCLEH)),
    .wdata (new_val[CNT_HALF_W-1:0]),
    .q     (mcycle_q)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .wr_lo (wr_en & (csr_addr == ADDR_MINSTRET)),
    .wr_hi (wr_en & (csr_addr == ADDR_MINSTRETH)),
    .wdata (new_val[CNT_HALF_W-1:0]),
    .q     (minstret_q)
  );

endmodule
